riscv_decode_stage: RTL and testbench
=====================================

Name: riscv_decode_stage

Overview:
- Registered RV32IM decode stage between fetch and rename/dispatch.
- Inverts the ISA encoding tables: a raw 32-bit instruction and its PC become a micro-op with control flags, register indices, a sign-extended immediate and an illegal-instruction flag.
- Valid/ready on both sides, 2-entry buffering (output register plus skid), flush for redirects.

Parameters:
- ADDR_BITS, 32, PC width (CPU_ADDR_BITS)
- INST_BITS, 32, instruction width (CPU_INST_BITS)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all buffered/in-flight micro-ops
- inst_valid  in  1  fetch offers an instruction
- inst_ready  out  1  stage can accept this cycle
- inst  in  32  raw instruction
- inst_pc  in  32  instruction PC
- uop_valid  out  1  micro-op outputs valid
- uop_ready  in  1  downstream accepts
- uop_pc  out  32  PC of the micro-op
- uop_rd/uop_rs1/uop_rs2  out  5 each  register indices
- uop_imm  out  32  sign-extended immediate
- uop_funct3  out  3  inst[14:12]
- uop_alu_op  out  4  {sub/sra bit, funct3}
- uop_uses_rs1/uop_uses_rs2/uop_writes_rd  out  1 each  operand and writeback usage
- uop_is_load/is_store/is_branch/is_jal/is_jalr/is_lui/is_auipc/is_muldiv/is_csr  out  1 each  class flags, one-hot when legal
- uop_csr_addr  out  12  inst[31:20]
- uop_illegal  out  1  instruction not legal RV32IM/CSR

Behaviour:
- Latency: 1 cycle. An instruction accepted in cycle N (inst_valid & inst_ready) appears on uop_* in cycle N+1 if the output register is empty or draining.
- Storage: output register (uop_valid) and skid entry (skid_valid).
  - inst_ready = ~skid_valid & ~rst. It is a registered state bit, with no combinational path from uop_ready.
  - Accept when the output is full and not consumed: the instruction goes to skid.
  - Output consumed (uop_valid & uop_ready): the output loads skid if skid_valid, else the new accept, else clears.
  - No bubbles at full throughput: with uop_ready held at 1, one micro-op per cycle.
- Flush: highest priority. The next cycle has uop_valid=0 and skid_valid=0. An instruction accepted in the flush cycle is dropped.
- Reset: uop_valid=0, skid_valid=0, inst_ready=0 while rst=1. All uop_* data outputs are 0.
- Stability: uop_* held constant while uop_valid & ~uop_ready.
- Immediates:
  - I: inst[31:20] sign-extended.
  - S: {inst[31:25],inst[11:7]}.
  - B: {inst[31],inst[7],inst[30:25],inst[11:8],0}.
  - U: {inst[31:12],12'b0}.
  - J: {inst[31],inst[19:12],inst[20],inst[30:21],0}.
  - R/CSR: 0.
- Operand usage:
  - uses_rs1: LOAD, STORE, BRANCH, JALR, ARI_I, ARI_R, and CSR with funct3[2]=0.
  - uses_rs2: STORE, BRANCH, ARI_R.
  - writes_rd: LUI, AUIPC, JAL, JALR, LOAD, ARI_I, ARI_R, CSR, and only when rd!=0 and not illegal.
- ALU op:
  - ARI_R non-muldiv: {inst[30],funct3}.
  - ARI_I: {funct3==101 ? inst[30] : 0, funct3}.
  - All others: 4'b0000.
- is_muldiv: ARI_R with funct7=0000001. The M operation is taken from uop_funct3.
- Illegal conditions (any one sets uop_illegal=1 and forces all class flags and writes_rd to 0):
  - inst[1:0]!=11, or unknown opcode.
  - ARI_R funct7 not in {0000000, 0100000, 0000001}, or 0100000 with funct3 not ADD_SUB/SRL_SRA.
  - ARI_I funct3=001 with funct7!=0, or funct3=101 with funct7 not 0/0100000.
  - LOAD funct3 in {011,110,111}; STORE funct3>010; BRANCH funct3 in {010,011}; JALR funct3!=000; CSR funct3=100.
- Illegal micro-ops still flow through the handshake; the ROB raises the exception.

Test Plan:
- Reset then one instruction: inst=0x002081B3 (add x3,x1,x2) -> next cycle uop_valid=1, rd=3, rs1=1, rs2=2, alu_op=0000, uses_rs1/rs2=1, writes_rd=1, illegal=0.
- Immediates: 0x402081B3 -> alu_op=1000. 0xFFC12283 (lw x5,-4(x2)) -> is_load=1, imm=0xFFFFFFFC, funct3=010. 0x008000EF (jal x1,8) -> is_jal=1, imm=8, rd=1.
- M extension and x0: 0x02C58533 (mul x10,x11,x12) -> is_muldiv=1, funct3=000, rd=10. 0x00000013 (nop) -> writes_rd=0, illegal=0.
- Illegal: 0xFFFFFFFF and 0x0000A003 (load funct3=010? no — use 0x0000B003, funct3=011) -> illegal=1, all class flags 0, writes_rd=0, handshake completes normally.
- Backpressure: stream 4 instructions with uop_ready=0 for 3 cycles.
  - Exactly 2 accepted; inst_ready=0 after the 2nd.
  - On uop_ready=1, order is preserved with no drops or duplicates, then full throughput of 1 per cycle.
- Flush: output and skid both full, flush=1 with inst_valid=1 -> next cycle uop_valid=0, inst_ready=1. The flushed-cycle instruction never appears.

Source files
------------

// File: rtl/riscv_decode_stage.sv
// rtl/riscv_decode_stage.sv - RV32IM decode stage with registered output and skid entry
// Raw instruction + PC in, decoded micro-op out, valid/ready on both sides, flush for redirects.
module riscv_decode_stage #(
  parameter int ADDR_BITS = 32,
  parameter int INST_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 inst_valid,
  output logic                 inst_ready,
  input  logic [INST_BITS-1:0] inst,
  input  logic [ADDR_BITS-1:0] inst_pc,
  output logic                 uop_valid,
  input  logic                 uop_ready,
  output logic [ADDR_BITS-1:0] uop_pc,
  output logic [4:0]           uop_rd,
  output logic [4:0]           uop_rs1,
  output logic [4:0]           uop_rs2,
  output logic [31:0]          uop_imm,
  output logic [2:0]           uop_funct3,
  output logic [3:0]           uop_alu_op,
  output logic                 uop_uses_rs1,
  output logic                 uop_uses_rs2,
  output logic                 uop_writes_rd,
  output logic                 uop_is_load,
  output logic                 uop_is_store,
  output logic                 uop_is_branch,
  output logic                 uop_is_jal,
  output logic                 uop_is_jalr,
  output logic                 uop_is_lui,
  output logic                 uop_is_auipc,
  output logic                 uop_is_muldiv,
  output logic                 uop_is_csr,
  output logic [11:0]          uop_csr_addr,
  output logic                 uop_illegal
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ARI_I  = 7'b0010011;
  localparam logic [6:0] OP_ARI_R  = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [ADDR_BITS-1:0] pc;
    logic [4:0]           rd;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [31:0]          imm;
    logic [2:0]           funct3;
    logic [3:0]           alu_op;
    logic                 uses_rs1;
    logic                 uses_rs2;
    logic                 writes_rd;
    logic                 is_load;
    logic                 is_store;
    logic                 is_branch;
    logic                 is_jal;
    logic                 is_jalr;
    logic                 is_lui;
    logic                 is_auipc;
    logic                 is_muldiv;
    logic                 is_csr;
    logic [11:0]          csr_addr;
    logic                 illegal;
  } uop_t;

  uop_t dec, out_q, skid_q;
  logic skid_valid;

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [8:0]  cls;
  logic        legal, cls_wr;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'b0};
  assign imm_j  = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

  // cls bit order: load, store, branch, jal, jalr, lui, auipc, muldiv, csr
  always_comb begin
    dec          = '0;
    cls          = '0;
    legal        = 1'b0;
    cls_wr       = 1'b0;
    dec.pc       = inst_pc;
    dec.rd       = inst[11:7];
    dec.rs1      = inst[19:15];
    dec.rs2      = inst[24:20];
    dec.funct3   = funct3;
    dec.csr_addr = inst[31:20];
    case (opcode)
      OP_LUI: begin
        cls = 9'b000001000; dec.imm = imm_u; cls_wr = 1'b1; legal = 1'b1;
      end
      OP_AUIPC: begin
        cls = 9'b000000100; dec.imm = imm_u; cls_wr = 1'b1; legal = 1'b1;
      end
      OP_JAL: begin
        cls = 9'b000100000; dec.imm = imm_j; cls_wr = 1'b1; legal = 1'b1;
      end
      OP_JALR: begin
        cls = 9'b000010000; dec.imm = imm_i; cls_wr = 1'b1; dec.uses_rs1 = 1'b1;
        legal = (funct3 == 3'b000);
      end
      OP_BRANCH: begin
        cls = 9'b001000000; dec.imm = imm_b; dec.uses_rs1 = 1'b1; dec.uses_rs2 = 1'b1;
        legal = (funct3 != 3'b010) && (funct3 != 3'b011);
      end
      OP_LOAD: begin
        cls = 9'b100000000; dec.imm = imm_i; cls_wr = 1'b1; dec.uses_rs1 = 1'b1;
        legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
      end
      OP_STORE: begin
        cls = 9'b010000000; dec.imm = imm_s; dec.uses_rs1 = 1'b1; dec.uses_rs2 = 1'b1;
        legal = (funct3 <= 3'b010);
      end
      OP_ARI_I: begin
        dec.imm      = imm_i;
        cls_wr       = 1'b1;
        dec.uses_rs1 = 1'b1;
        dec.alu_op   = {(funct3 == 3'b101) & inst[30], funct3};
        legal        = !((funct3 == 3'b001) && (funct7 != 7'b0000000)) &&
                       !((funct3 == 3'b101) && (funct7 != 7'b0000000) && (funct7 != 7'b0100000));
      end
      OP_ARI_R: begin
        cls_wr       = 1'b1;
        dec.uses_rs1 = 1'b1;
        dec.uses_rs2 = 1'b1;
        if (funct7 == 7'b0000001) cls = 9'b000000010;
        else                      dec.alu_op = {inst[30], funct3};
        legal = (funct7 == 7'b0000000) || (funct7 == 7'b0000001) ||
                ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
      OP_SYSTEM: begin
        cls = 9'b000000001; cls_wr = 1'b1; dec.uses_rs1 = ~funct3[2];
        legal = (funct3 != 3'b100);
      end
      default: legal = 1'b0;
    endcase
    {dec.is_load, dec.is_store, dec.is_branch, dec.is_jal, dec.is_jalr,
     dec.is_lui, dec.is_auipc, dec.is_muldiv, dec.is_csr} = legal ? cls : 9'b0;
    dec.writes_rd = cls_wr & legal & (dec.rd != 5'd0);
    dec.illegal   = ~legal;
  end

  assign inst_ready = ~skid_valid & ~rst;

  // The output register refills from skid first so program order is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      uop_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      uop_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!uop_valid || uop_ready) begin
      if (skid_valid) begin
        out_q      <= skid_q;
        uop_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (inst_valid && inst_ready) begin
        out_q     <= dec;
        uop_valid <= 1'b1;
      end else begin
        uop_valid <= 1'b0;
      end
    end else if (inst_valid && inst_ready) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end
  end

  assign uop_pc        = out_q.pc;
  assign uop_rd        = out_q.rd;
  assign uop_rs1       = out_q.rs1;
  assign uop_rs2       = out_q.rs2;
  assign uop_imm       = out_q.imm;
  assign uop_funct3    = out_q.funct3;
  assign uop_alu_op    = out_q.alu_op;
  assign uop_uses_rs1  = out_q.uses_rs1;
  assign uop_uses_rs2  = out_q.uses_rs2;
  assign uop_writes_rd = out_q.writes_rd;
  assign uop_is_load   = out_q.is_load;
  assign uop_is_store  = out_q.is_store;
  assign uop_is_branch = out_q.is_branch;
  assign uop_is_jal    = out_q.is_jal;
  assign uop_is_jalr   = out_q.is_jalr;
  assign uop_is_lui    = out_q.is_lui;
  assign uop_is_auipc  = out_q.is_auipc;
  assign uop_is_muldiv = out_q.is_muldiv;
  assign uop_is_csr    = out_q.is_csr;
  assign uop_csr_addr  = out_q.csr_addr;
  assign uop_illegal   = out_q.illegal;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// tb/tb_riscv_decode_stage.sv - self-checking bench for riscv_decode_stage
module tb_riscv_decode_stage;

  logic        clk, rst, flush, inst_valid, inst_ready, uop_valid, uop_ready;
  logic [31:0] inst, inst_pc, uop_pc, uop_imm;
  logic [4:0]  uop_rd, uop_rs1, uop_rs2;
  logic [2:0]  uop_funct3;
  logic [3:0]  uop_alu_op;
  logic        uop_uses_rs1, uop_uses_rs2, uop_writes_rd;
  logic        uop_is_load, uop_is_store, uop_is_branch, uop_is_jal, uop_is_jalr;
  logic        uop_is_lui, uop_is_auipc, uop_is_muldiv, uop_is_csr, uop_illegal;
  logic [11:0] uop_csr_addr;

  riscv_decode_stage #(.ADDR_BITS(32), .INST_BITS(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .uop_valid(uop_valid), .uop_ready(uop_ready), .uop_pc(uop_pc),
    .uop_rd(uop_rd), .uop_rs1(uop_rs1), .uop_rs2(uop_rs2), .uop_imm(uop_imm),
    .uop_funct3(uop_funct3), .uop_alu_op(uop_alu_op),
    .uop_uses_rs1(uop_uses_rs1), .uop_uses_rs2(uop_uses_rs2), .uop_writes_rd(uop_writes_rd),
    .uop_is_load(uop_is_load), .uop_is_store(uop_is_store), .uop_is_branch(uop_is_branch),
    .uop_is_jal(uop_is_jal), .uop_is_jalr(uop_is_jalr), .uop_is_lui(uop_is_lui),
    .uop_is_auipc(uop_is_auipc), .uop_is_muldiv(uop_is_muldiv), .uop_is_csr(uop_is_csr),
    .uop_csr_addr(uop_csr_addr), .uop_illegal(uop_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flags: {load, store, branch, jal, jalr, lui, auipc, muldiv, csr}
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic [3:0]  alu;
    logic        u1, u2, wr;
    logic [8:0]  flags;
    logic [11:0] csr;
    logic        ill;
  } exp_t;

  exp_t obs;
  assign obs = {uop_pc, uop_rd, uop_rs1, uop_rs2, uop_imm, uop_funct3, uop_alu_op,
                uop_uses_rs1, uop_uses_rs2, uop_writes_rd,
                uop_is_load, uop_is_store, uop_is_branch, uop_is_jal, uop_is_jalr,
                uop_is_lui, uop_is_auipc, uop_is_muldiv, uop_is_csr, uop_csr_addr, uop_illegal};

  int checks = 0;
  int errors = 0;

  function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc);
    exp_t        e;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] hi;
    logic        legal, wr;
    f3 = i[14:12];
    f7 = i[31:25];
    hi = i[31] ? 32'hFFFF_F000 : 32'h0;
    e = '0;
    e.pc = pc; e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.f3 = f3; e.csr = i[31:20];
    legal = 1'b1;
    wr = 1'b0;
    case (i[6:0])
      7'h37: begin e.flags = 9'(1 << 3); e.imm = i & 32'hFFFF_F000; wr = 1'b1; end
      7'h17: begin e.flags = 9'(1 << 2); e.imm = i & 32'hFFFF_F000; wr = 1'b1; end
      7'h6F: begin
        e.flags = 9'(1 << 5); wr = 1'b1;
        e.imm = (i[31] ? 32'hFFF0_0000 : 32'h0) | (32'(i[19:12]) << 12) |
                (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
      end
      7'h67: begin e.flags = 9'(1 << 4); e.imm = hi | 32'(i[31:20]); e.u1 = 1; wr = 1; legal = (f3 == 0); end
      7'h63: begin
        e.flags = 9'(1 << 6); e.u1 = 1; e.u2 = 1; legal = f3 inside {0, 1, 4, 5, 6, 7};
        e.imm = hi | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
      end
      7'h03: begin e.flags = 9'(1 << 8); e.imm = hi | 32'(i[31:20]); e.u1 = 1; wr = 1; legal = f3 inside {0, 1, 2, 4, 5}; end
      7'h23: begin
        e.flags = 9'(1 << 7); e.u1 = 1; e.u2 = 1; legal = f3 inside {0, 1, 2};
        e.imm = hi | (32'(i[31:25]) << 5) | 32'(i[11:7]);
      end
      7'h13: begin
        e.imm = hi | 32'(i[31:20]); e.u1 = 1; wr = 1;
        e.alu = {(f3 == 5) ? i[30] : 1'b0, f3};
        legal = !((f3 == 1 && f7 != 0) || (f3 == 5 && !(f7 inside {7'h00, 7'h20})));
      end
      7'h33: begin
        e.u1 = 1; e.u2 = 1; wr = 1;
        if (f7 == 7'h01) e.flags = 9'(1 << 1);
        else             e.alu = {i[30], f3};
        legal = (f7 == 7'h00) || (f7 == 7'h01) || (f7 == 7'h20 && f3 inside {0, 5});
      end
      7'h73: begin e.flags = 9'(1 << 0); e.u1 = !f3[2]; wr = 1; legal = (f3 != 4); end
      default: legal = 1'b0;
    endcase
    if (!legal) e.flags = '0;
    e.ill = !legal;
    e.wr = wr && legal && (e.rd != 0);
    return e;
  endfunction

  function automatic logic [22:0] key_of(input exp_t e);
    return {e.ill, e.wr, e.flags, e.alu, e.f3, e.rd};
  endfunction

  logic [31:0] dvec [8] = '{32'h002081B3, 32'h402081B3, 32'hFFC12283, 32'h008000EF,
                            32'h02C58533, 32'h00000013, 32'hFFFFFFFF, 32'h0000B003};
  logic [22:0] dkey [8] = '{{1'b0, 1'b1, 9'h000, 4'h0, 3'd0, 5'd3},
                            {1'b0, 1'b1, 9'h000, 4'h8, 3'd0, 5'd3},
                            {1'b0, 1'b1, 9'h100, 4'h0, 3'd2, 5'd5},
                            {1'b0, 1'b1, 9'h020, 4'h0, 3'd0, 5'd1},
                            {1'b0, 1'b1, 9'h002, 4'h0, 3'd0, 5'd10},
                            {1'b0, 1'b0, 9'h000, 4'h0, 3'd0, 5'd0},
                            {1'b1, 1'b0, 9'h000, 4'h0, 3'd7, 5'd31},
                            {1'b1, 1'b0, 9'h000, 4'h0, 3'd3, 5'd0}};
  logic [31:0] dimm [8] = '{32'h0, 32'h0, 32'hFFFF_FFFC, 32'h8, 32'h0, 32'h0, 32'h0, 32'h0};

  task automatic test_reset();
    rst = 1; flush = 0; inst_valid = 1; inst = dvec[0]; inst_pc = 32'h100; uop_ready = 0;
    repeat (3) @(negedge clk);
    checks++; if (uop_valid !== 1'b0) $display("FAIL reset_uop_valid got=%b want=0", uop_valid);
    if (uop_valid !== 1'b0) errors++;
    checks++; if (inst_ready !== 1'b0) begin $display("FAIL reset_inst_ready got=%b want=0", inst_ready); errors++; end
    checks++; if (obs !== '0) begin $display("FAIL reset_data got=%h want=0", obs); errors++; end
    rst = 0; inst_valid = 0;
    @(negedge clk);
    checks++; if (inst_ready !== 1'b1) begin $display("FAIL post_reset_ready got=%b want=1", inst_ready); errors++; end
    checks++; if (uop_valid !== 1'b0) begin $display("FAIL post_reset_valid got=%b want=0", uop_valid); errors++; end
  endtask

  task automatic test_directed();
    exp_t e;
    uop_ready = 1;
    for (int k = 0; k < 8; k++) begin
      inst_valid = 1; inst = dvec[k]; inst_pc = 32'h1000 + 32'(4 * k);
      e = model(dvec[k], inst_pc);
      @(negedge clk);
      checks++; if (uop_valid !== 1'b1) begin $display("FAIL dir_valid[%0d] got=%b want=1", k, uop_valid); errors++; end
      checks++; if (obs !== e) begin $display("FAIL dir_uop[%0d] got=%h want=%h", k, obs, e); errors++; end
      checks++; if (key_of(obs) !== dkey[k]) begin $display("FAIL dir_key[%0d] got=%h want=%h", k, key_of(obs), dkey[k]); errors++; end
      checks++; if (uop_imm !== dimm[k]) begin $display("FAIL dir_imm[%0d] got=%h want=%h", k, uop_imm, dimm[k]); errors++; end
    end
    checks++; if (uop_uses_rs1 !== 1'b1 || uop_is_load !== 1'b0) begin
      $display("FAIL dir_illegal_load got uses_rs1=%b is_load=%b want 1 0", uop_uses_rs1, uop_is_load); errors++; end
    inst_valid = 0;
    @(negedge clk);
    checks++; if (uop_valid !== 1'b0) begin $display("FAIL dir_drain got=%b want=0", uop_valid); errors++; end
  endtask

  task automatic test_back_to_back();
    exp_t q[$];
    exp_t e;
    int   idx, got, cyc;
    logic acc;
    idx = 0; uop_ready = 0;
    for (int c = 0; c < 3; c++) begin
      inst_valid = 1; inst = dvec[idx]; inst_pc = 32'h2000 + 32'(4 * idx);
      acc = inst_ready;
      if (acc) q.push_back(model(inst, inst_pc));
      @(negedge clk);
      if (acc) idx++;
    end
    checks++; if (idx != 2) begin $display("FAIL bp_accepted got=%0d want=2", idx); errors++; end
    checks++; if (inst_ready !== 1'b0) begin $display("FAIL bp_ready got=%b want=0", inst_ready); errors++; end
    uop_ready = 1; got = 0; cyc = 0;
    while (got < 4 && cyc < 10) begin
      inst_valid = (idx < 4);
      inst = dvec[idx % 8]; inst_pc = 32'h2000 + 32'(4 * idx);
      acc = inst_valid && inst_ready;
      if (acc) q.push_back(model(inst, inst_pc));
      if (uop_valid) begin
        e = q.pop_front();
        checks++; if (obs !== e) begin $display("FAIL bp_order[%0d] got=%h want=%h", got, obs, e); errors++; end
        got++;
      end
      @(negedge clk);
      cyc++;
      if (acc) idx++;
    end
    inst_valid = 0;
    checks++; if (got != 4 || cyc != 4) begin $display("FAIL bp_throughput got=%0d/%0d cycles want=4/4", got, cyc); errors++; end
    checks++; if (uop_valid !== 1'b0) begin $display("FAIL bp_empty got=%b want=0", uop_valid); errors++; end
  endtask

  task automatic test_flush();
    int seen;
    uop_ready = 0; inst_valid = 1; inst = dvec[0]; inst_pc = 32'h3000;
    @(negedge clk);
    inst = dvec[1]; inst_pc = 32'h3004;
    @(negedge clk);
    checks++; if (inst_ready !== 1'b0 || uop_valid !== 1'b1) begin
      $display("FAIL flush_fill got ready=%b valid=%b want 0 1", inst_ready, uop_valid); errors++; end
    flush = 1; inst = dvec[2]; inst_pc = 32'h3008;
    @(negedge clk);
    flush = 0; inst_valid = 0;
    checks++; if (uop_valid !== 1'b0 || inst_ready !== 1'b1) begin
      $display("FAIL flush_full got valid=%b ready=%b want 0 1", uop_valid, inst_ready); errors++; end
    uop_ready = 1; seen = 0;
    repeat (3) begin @(negedge clk); if (uop_valid) seen++; end
    checks++; if (seen != 0) begin $display("FAIL flush_residue got=%0d want=0", seen); errors++; end
    flush = 1; inst_valid = 1; inst = dvec[3]; inst_pc = 32'h300C;
    @(negedge clk);
    flush = 0; inst_valid = 0;
    checks++; if (uop_valid !== 1'b0) begin $display("FAIL flush_drop got=%b want=0", uop_valid); errors++; end
    inst_valid = 1; inst = dvec[4]; inst_pc = 32'h3010;
    @(negedge clk);
    inst_valid = 0;
    checks++; if (uop_valid !== 1'b1 || uop_pc !== 32'h3010) begin
      $display("FAIL flush_resume got valid=%b pc=%h want 1 3010", uop_valid, uop_pc); errors++; end
    @(negedge clk);
  endtask

  task automatic test_random();
    exp_t        q[$];
    exp_t        e, prev;
    logic        stall;
    logic [31:0] r;
    logic [6:0]  ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73, 7'h0F};
    int          sel, t;
    stall = 0;
    prev = '0;
    for (int c = 0; c < 800; c++) begin
      if (stall) begin
        checks++; if (obs !== prev || uop_valid !== 1'b1) begin
          $display("FAIL rnd_stable[%0d] got=%h want=%h", c, obs, prev); errors++; end
      end
      checks++; if (uop_valid !== (q.size() > 0) || inst_ready !== (q.size() < 2)) begin
        $display("FAIL rnd_occupancy[%0d] got valid=%b ready=%b want occ=%0d", c, uop_valid, inst_ready, q.size()); errors++; end
      r = $urandom();
      sel = $urandom_range(0, 11);
      if ((sel == 7 || sel == 8) && $urandom_range(0, 1) == 1) begin
        t = $urandom_range(0, 2);
        r[31:25] = (t == 0) ? 7'h00 : (t == 1) ? 7'h20 : 7'h01;
      end
      inst = (sel == 11) ? r : {r[31:7], ops[sel]};
      inst_pc = $urandom();
      inst_valid = ($urandom_range(0, 3) != 0);
      uop_ready = ($urandom_range(0, 4) < 3);
      flush = ($urandom_range(0, 39) == 0);
      if (uop_valid && uop_ready) begin
        if (q.size() == 0) begin
          checks++; errors++; $display("FAIL rnd_spurious[%0d] got=%h", c, obs);
        end else begin
          e = q.pop_front();
          checks++; if (obs !== e) begin $display("FAIL rnd_uop[%0d] got=%h want=%h", c, obs, e); errors++; end
        end
      end
      if (flush) q.delete();
      else if (inst_valid && inst_ready) q.push_back(model(inst, inst_pc));
      stall = uop_valid && !uop_ready && !flush;
      prev = obs;
      @(negedge clk);
    end
    flush = 0; inst_valid = 0; uop_ready = 1;
    for (int c = 0; c < 10 && q.size() > 0; c++) begin
      if (uop_valid) begin
        e = q.pop_front();
        checks++; if (obs !== e) begin $display("FAIL rnd_drain got=%h want=%h", obs, e); errors++; end
      end
      @(negedge clk);
    end
    checks++; if (q.size() != 0 || uop_valid !== 1'b0) begin
      $display("FAIL rnd_final got pending=%0d valid=%b want 0 0", q.size(), uop_valid); errors++; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
